// File: rtl/button_pkg.sv
// Shared definitions for the button debouncer.
// Holds the default channel count and debounce length, the event channel
// width, the packed event layout {chan, press}, and a lowest-set-bit helper
// used by the event priority encoder.
package button_pkg;

  localparam int BTN_CHAN_W          = 3;
  localparam int N_BTN_DEF           = 7;
  localparam int DEBOUNCE_CYCLES_DEF = 20000;

  typedef struct packed {
    logic [BTN_CHAN_W-1:0] chan;
    logic                  press;
  } evt_t;

  // Index of the lowest set bit; 0 when nothing is set (callers gate on |v).
  function automatic logic [BTN_CHAN_W-1:0] lowest_set(input logic [7:0] v);
    logic [BTN_CHAN_W-1:0] idx;
    idx = '0;
    for (int i = 7; i >= 0; i--) begin
      if (v[i]) idx = BTN_CHAN_W'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/button_debounce_chan.sv
// One debounced button channel.
// Ports:
//   i_clk, i_rst   : clock, asynchronous active-high reset
//   i_btn          : raw pad input, asynchronous to i_clk
//   o_level        : debounced stable level
//   o_rise/o_fall  : one-cycle pulses, coincident with the new o_level
//   o_edge         : combinational, high in the cycle before o_level flips
//   o_edge_dir     : level o_level will take when o_edge is high
module debounce_chan
  import button_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES)
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_btn,
  output logic o_level,
  output logic o_rise,
  output logic o_fall,
  output logic o_edge,
  output logic o_edge_dir
);

  logic             r_s1;
  logic             r_s2;
  logic             r_level;
  logic             r_rise;
  logic             r_fall;
  logic [CNT_W-1:0] r_cnt;

  logic w_diff;
  logic w_at_thr;
  logic w_edge;

  assign w_diff   = (r_s2 != r_level);
  assign w_at_thr = (r_cnt == CNT_W'(DEBOUNCE_CYCLES - 1));
  assign w_edge   = w_diff && w_at_thr;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_s1    <= 1'b0;
      r_s2    <= 1'b0;
      r_level <= 1'b0;
      r_cnt   <= '0;
      r_rise  <= 1'b0;
      r_fall  <= 1'b0;
    end else begin
      r_s1   <= i_btn;
      r_s2   <= r_s1;
      r_rise <= w_edge && r_s2;
      r_fall <= w_edge && !r_s2;
      // Any return to the stable level discards the partial count.
      if (!w_diff) begin
        r_cnt <= '0;
      end else if (w_at_thr) begin
        r_cnt   <= '0;
        r_level <= r_s2;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  assign o_level    = r_level;
  assign o_rise     = r_rise;
  assign o_fall     = r_fall;
  assign o_edge     = w_edge;
  assign o_edge_dir = r_s2;

endmodule

// File: rtl/button_debounce.sv
// Debounces N_BTN asynchronous button pads and reports stable levels,
// per-channel rise/fall pulses, and a press/release event stream over a
// valid/ready handshake. Events wait in a per-channel pending bit until the
// event register is free; the lowest pending channel is served first. A
// second edge on a channel whose pending event has not been taken sets the
// sticky ovr flag and overwrites the pending direction.
// Ports:
//   wb_clk_i, wb_rst_i          : clock, asynchronous active-high reset
//   btn_in                      : raw pads
//   btn_oeb                     : pad output-enable-bar, always input mode
//   btn_level/btn_rise/btn_fall : debounced level and edge pulses
//   evt_valid/evt_ready         : event handshake
//   evt_chan/evt_press          : event payload
//   ovr/ovr_clr                 : sticky overrun flag and its clear pulse
module button_debounce
  import button_pkg::*;
#(
  parameter int N_BTN           = N_BTN_DEF,
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES)
) (
  input  logic                  wb_clk_i,
  input  logic                  wb_rst_i,
  input  logic [N_BTN-1:0]      btn_in,
  output logic [N_BTN-1:0]      btn_oeb,
  output logic [N_BTN-1:0]      btn_level,
  output logic [N_BTN-1:0]      btn_rise,
  output logic [N_BTN-1:0]      btn_fall,
  output logic                  evt_valid,
  input  logic                  evt_ready,
  output logic [BTN_CHAN_W-1:0] evt_chan,
  output logic                  evt_press,
  output logic                  ovr,
  input  logic                  ovr_clr
);

  logic [N_BTN-1:0]      w_edge;
  logic [N_BTN-1:0]      w_dir;
  logic [N_BTN-1:0]      w_clr;
  logic [7:0]            w_pend8;
  logic [7:0]            w_pdir8;
  logic [BTN_CHAN_W-1:0] w_idx;
  logic                  w_any;
  logic                  w_load;
  logic                  w_take;
  logic                  w_ovr_set;

  logic [N_BTN-1:0] r_pend;
  logic [N_BTN-1:0] r_pdir;
  logic             r_valid;
  evt_t             r_evt;
  logic             r_ovr;

  for (genvar g = 0; g < N_BTN; g++) begin : g_chan
    debounce_chan #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .CNT_W           (CNT_W)
    ) u_chan (
      .i_clk      (wb_clk_i),
      .i_rst      (wb_rst_i),
      .i_btn      (btn_in[g]),
      .o_level    (btn_level[g]),
      .o_rise     (btn_rise[g]),
      .o_fall     (btn_fall[g]),
      .o_edge     (w_edge[g]),
      .o_edge_dir (w_dir[g])
    );
  end

  always_comb begin
    w_pend8 = 8'(r_pend);
    w_pdir8 = 8'(r_pdir);
    w_any   = |r_pend;
    w_idx   = lowest_set(w_pend8);
    w_load  = !r_valid || evt_ready;
    w_take  = w_load && w_any;
    w_clr   = '0;
    for (int i = 0; i < N_BTN; i++) begin
      w_clr[i] = w_take && (w_idx == BTN_CHAN_W'(i));
    end
    // A fresh edge on a channel being handed off this cycle simply re-arms
    // it; only an edge on a pending, untaken channel loses an event.
    w_ovr_set = |(w_edge & r_pend & ~w_clr);
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      r_pend  <= '0;
      r_pdir  <= '0;
      r_valid <= 1'b0;
      r_evt   <= '0;
      r_ovr   <= 1'b0;
    end else begin
      // Set beats clear when an edge lands on the channel being loaded.
      r_pend <= (r_pend & ~w_clr) | w_edge;
      r_pdir <= (r_pdir & ~w_edge) | (w_dir & w_edge);
      if (w_load) begin
        r_valid <= w_any;
        if (w_any) begin
          r_evt.chan  <= w_idx;
          r_evt.press <= w_pdir8[w_idx];
        end
      end
      if (w_ovr_set) begin
        r_ovr <= 1'b1;
      end else if (ovr_clr) begin
        r_ovr <= 1'b0;
      end
    end
  end

  assign btn_oeb   = '1;
  assign evt_valid = r_valid;
  assign evt_chan  = r_evt.chan;
  assign evt_press = r_evt.press;
  assign ovr       = r_ovr;

endmodule

// File: tb/tb_button_debounce.sv
// Directed bench for button_debounce with a 4-cycle debounce window.
// Inputs change 1 ns after a rising edge; outputs are checked 1 ns after
// each rising edge. "After Ek" below means after the k-th edge counted from
// the first edge that samples the new pad value (E0).
module tb_button_debounce;

  localparam int NB = 7;

  logic          clk = 1'b0;
  logic          rst;
  logic [NB-1:0] btn_in;
  logic [NB-1:0] btn_oeb;
  logic [NB-1:0] btn_level;
  logic [NB-1:0] btn_rise;
  logic [NB-1:0] btn_fall;
  logic          evt_valid;
  logic          evt_ready;
  logic [2:0]    evt_chan;
  logic          evt_press;
  logic          ovr;
  logic          ovr_clr;

  int n_vec = 0;
  int n_err = 0;

  button_debounce #(
    .N_BTN           (NB),
    .DEBOUNCE_CYCLES (4)
  ) dut (
    .wb_clk_i  (clk),
    .wb_rst_i  (rst),
    .btn_in    (btn_in),
    .btn_oeb   (btn_oeb),
    .btn_level (btn_level),
    .btn_rise  (btn_rise),
    .btn_fall  (btn_fall),
    .evt_valid (evt_valid),
    .evt_ready (evt_ready),
    .evt_chan  (evt_chan),
    .evt_press (evt_press),
    .ovr       (ovr),
    .ovr_clr   (ovr_clr)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_level"}, 32'(btn_level), 32'h0);
    chk({tag, "_rise"},  32'(btn_rise),  32'h0);
    chk({tag, "_fall"},  32'(btn_fall),  32'h0);
    chk({tag, "_valid"}, 32'(evt_valid), 32'h0);
    chk({tag, "_chan"},  32'(evt_chan),  32'h0);
    chk({tag, "_press"}, 32'(evt_press), 32'h0);
    chk({tag, "_ovr"},   32'(ovr),       32'h0);
    chk({tag, "_oeb"},   32'(btn_oeb),   32'h7f);
  endtask

  initial begin
    rst       = 1'b1;
    btn_in    = '0;
    evt_ready = 1'b1;
    ovr_clr   = 1'b0;
    #1;
    chk_reset_vals("rst0");
    step(2);
    rst = 1'b0;

    // 1. Clean press and release on channel 3.
    btn_in[3] = 1'b1;
    step(5);                                   // after E4
    chk("s1_lvl_E4", 32'(btn_level), 32'h00);
    step(1);                                   // after E5
    chk("s1_lvl_E5", 32'(btn_level), 32'h08);
    chk("s1_rise_E5", 32'(btn_rise), 32'h08);
    chk("s1_val_E5", 32'(evt_valid), 32'h0);
    step(1);                                   // after E6
    chk("s1_rise_E6", 32'(btn_rise), 32'h00);
    chk("s1_val_E6", 32'(evt_valid), 32'h1);
    chk("s1_chan_E6", 32'(evt_chan), 32'h3);
    chk("s1_press_E6", 32'(evt_press), 32'h1);
    step(1);
    chk("s1_val_E7", 32'(evt_valid), 32'h0);
    step(13);
    btn_in[3] = 1'b0;
    step(5);
    chk("s1r_lvl_E4", 32'(btn_level), 32'h08);
    step(1);
    chk("s1r_lvl_E5", 32'(btn_level), 32'h00);
    chk("s1r_fall_E5", 32'(btn_fall), 32'h08);
    step(1);
    chk("s1r_fall_E6", 32'(btn_fall), 32'h00);
    chk("s1r_val_E6", 32'(evt_valid), 32'h1);
    chk("s1r_chan_E6", 32'(evt_chan), 32'h3);
    chk("s1r_press_E6", 32'(evt_press), 32'h0);
    step(3);

    // 2. Three-cycle glitch on channel 0 is rejected.
    btn_in[0] = 1'b1;
    step(3);
    btn_in[0] = 1'b0;
    for (int k = 0; k < 8; k++) begin
      step(1);
      chk("s2_lvl", 32'(btn_level), 32'h00);
      chk("s2_rise", 32'(btn_rise), 32'h00);
      chk("s2_val", 32'(evt_valid), 32'h0);
    end

    // 3. Channels 5, 1, 6 together under 10 cycles of backpressure.
    evt_ready = 1'b0;
    btn_in    = 7'b110_0010;
    step(6);                                   // after E5
    chk("s3_lvl_E5", 32'(btn_level), 32'h62);
    chk("s3_val_E5", 32'(evt_valid), 32'h0);
    for (int k = 0; k < 4; k++) begin          // after E6..E9
      step(1);
      chk("s3_val_hold", 32'(evt_valid), 32'h1);
      chk("s3_chan_hold", 32'(evt_chan), 32'h1);
      chk("s3_press_hold", 32'(evt_press), 32'h1);
    end
    chk("s3_ovr", 32'(ovr), 32'h0);
    evt_ready = 1'b1;
    step(1);
    chk("s3_chan_2nd", 32'(evt_chan), 32'h5);
    chk("s3_val_2nd", 32'(evt_valid), 32'h1);
    step(1);
    chk("s3_chan_3rd", 32'(evt_chan), 32'h6);
    chk("s3_val_3rd", 32'(evt_valid), 32'h1);
    step(1);
    chk("s3_val_done", 32'(evt_valid), 32'h0);
    chk("s3_ovr_done", 32'(ovr), 32'h0);

    // 4. Overrun: channel 2 press then release while stalled; channel 0 press.
    evt_ready = 1'b0;
    btn_in[0] = 1'b1;
    btn_in[2] = 1'b1;
    step(7);                                   // after E6
    chk("s4_val", 32'(evt_valid), 32'h1);
    chk("s4_chan", 32'(evt_chan), 32'h0);
    chk("s4_ovr_pre", 32'(ovr), 32'h0);
    btn_in[2] = 1'b0;
    step(5);                                   // after E4 of release
    chk("s4_ovr_E4", 32'(ovr), 32'h0);
    step(1);                                   // after E5 of release
    chk("s4_ovr_E5", 32'(ovr), 32'h1);
    chk("s4_chan_held", 32'(evt_chan), 32'h0);
    chk("s4_press_held", 32'(evt_press), 32'h1);
    evt_ready = 1'b1;
    step(1);
    chk("s4_chan_2", 32'(evt_chan), 32'h2);
    chk("s4_press_2", 32'(evt_press), 32'h0);
    chk("s4_val_2", 32'(evt_valid), 32'h1);
    step(1);
    chk("s4_val_end", 32'(evt_valid), 32'h0);
    chk("s4_ovr_sticky", 32'(ovr), 32'h1);
    ovr_clr = 1'b1;
    step(1);
    ovr_clr = 1'b0;
    chk("s4_ovr_clr", 32'(ovr), 32'h0);

    // 5. Reset while channel 4 is mid-debounce (cnt == 2).
    btn_in = 7'b001_0000;
    step(4);                                   // after E3
    rst = 1'b1;
    #1;
    chk_reset_vals("s5_rst");
    step(2);
    rst = 1'b0;
    step(5);                                   // after E4 post-reset
    chk("s5_lvl_E4", 32'(btn_level), 32'h00);
    step(1);
    chk("s5_lvl_E5", 32'(btn_level), 32'h10);
    chk("s5_rise_E5", 32'(btn_rise), 32'h10);
    chk("s5_val_E5", 32'(evt_valid), 32'h0);
    step(1);
    chk("s5_val_E6", 32'(evt_valid), 32'h1);
    chk("s5_chan_E6", 32'(evt_chan), 32'h4);
    chk("s5_press_E6", 32'(evt_press), 32'h1);
    step(1);
    chk("s5_val_E7", 32'(evt_valid), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/button_debounce.md
# button_debounce

Input-side counterpart to the LED output driver inside `user_proj_example`: it samples N asynchronous button/switch pads from `io_in`, synchronizes and debounces each channel, and reports stable levels plus a press/release event stream through a valid/ready handshake. It sits between the user-area input pads and the user logic, which consumes events one at a time. A sticky flag reports any event lost because its channel was not drained in time.

## Interface
- `N_BTN`, 7, number of button channels; the range is 1..8.
- `DEBOUNCE_CYCLES`, 20000, number of consecutive cycles a new level must persist. At the 40 MHz `wb_clk_i` this is 0.5 ms. The minimum is 2.
- `CNT_W`, `$clog2(DEBOUNCE_CYCLES)`, width of the per-channel counter.
- `wb_clk_i` in 1: the single clock.
- `wb_rst_i` in 1: reset, asynchronous and active-high.
- `btn_in` in N_BTN: raw pad inputs from `io_in`, asynchronous to `wb_clk_i`.
- `btn_oeb` out N_BTN: pad output-enable-bar, tied to all ones (input mode).
- `btn_level` out N_BTN: debounced stable level per channel.
- `btn_rise` out N_BTN: one-cycle pulse per channel on a debounced 0→1 transition.
- `btn_fall` out N_BTN: one-cycle pulse per channel on a debounced 1→0 transition.
- `evt_valid` out 1: the event register holds an event.
- `evt_ready` in 1: the consumer accepts the event.
- `evt_chan` out 3: channel index of the event.
- `evt_press` out 1: 1 for press (0→1), 0 for release.
- `ovr` out 1: sticky overrun flag.
- `ovr_clr` in 1: one-cycle pulse that clears `ovr`.

## Operation
- **Synchronizer.** Each channel has a 2-flop synchronizer, `btn_in` → `s1` → `s2`.
- **Debounce**, evaluated every edge per channel:
  - If `s2 == level`: `cnt <= 0`.
  - Else if `cnt == DEBOUNCE_CYCLES-1`: `level <= s2`, `cnt <= 0`, and the matching rise/fall pulse is asserted in the same cycle as the new level.
  - Else: `cnt <= cnt+1`.
- **Glitches.** Any return of `s2` to the stable level before the threshold discards the count. A glitch shorter than `DEBOUNCE_CYCLES` never reaches `btn_level`.
- **Pending state.** Each channel has `pend[i]` and `pdir[i]`. A debounced edge sets `pend[i] <= 1` and `pdir[i] <=` the new level.
- **Event register.** It loads when `!evt_valid || evt_ready`:
  - If any `pend` bit is set, load the lowest set index `i`: `evt_chan <= i`, `evt_press <= pdir[i]`, `evt_valid <= 1`, and clear `pend[i]`.
  - Otherwise `evt_valid <= 0`.
- **Simultaneous edge and load, same channel.** If a new edge arrives on channel `i` in the cycle `pend[i]` is being loaded, the set wins: `pend[i]` stays 1 with the new `pdir`. No overrun.
- **Overrun.** An edge on a channel whose `pend` is already 1 and is not being loaded that cycle sets `ovr`. `pdir` takes the newest level, so the older event is lost.
- **Overrun clear.** `ovr_clr` clears `ovr`. If a set and `ovr_clr` occur in the same cycle, the set wins.
- **Output stability.** `evt_chan` and `evt_press` hold stable while `evt_valid && !evt_ready`.

## Timing
- **Reset values.** `wb_rst_i` forces, immediately and asynchronously:
  - `s1`, `s2`, `level`, `cnt`, `pend`, `pdir` = 0.
  - `btn_level` = 0, `btn_rise` = 0, `btn_fall` = 0.
  - `evt_valid` = 0, `evt_chan` = 0, `evt_press` = 0, `ovr` = 0.
  - `btn_oeb` = all ones.
- **Reset mid-operation** discards all counts and pending events.
- **Button held through reset release** yields a press event after the normal latency, because `level` resets to 0.
- **Latency.** Let E0 be the first edge that samples the new pad value.
  - `btn_level` and the rise/fall pulse update at edge E(D+1), where D = `DEBOUNCE_CYCLES`.
  - `pend` sets at edge E(D+1).
  - `evt_valid` rises at edge E(D+2) if the event register is free.
- **Throughput.** One event per cycle under `evt_ready = 1`.
- **Priority.** When several channels change in the same cycle, events are delivered in ascending channel index on consecutive cycles.

## Structure
- **Shared package `button_pkg`:**
  - `BTN_CHAN_W` = 3.
  - Default `N_BTN`.
  - Default `DEBOUNCE_CYCLES`.
  - Event field layout `{chan, press}`.
- **Sub-module `debounce_chan`:** the synchronizer, counter, level, and rise/fall pulse for one channel, instantiated `N_BTN` times through a generate loop.
- **Top level:** pending bits, lowest-index priority encoder, event register, and overrun logic.

## Test plan
All scenarios run with `DEBOUNCE_CYCLES` = 4 and `evt_ready` = 1 unless stated.
1. **Clean press.** Assert `btn_in[3]` = 1 and hold.
   - At E5: `btn_level[3]` = 1 and `btn_rise[3]` pulses for one cycle.
   - At E6: `evt_valid` = 1, `evt_chan` = 3, `evt_press` = 1.
   - Release after 20 cycles gives `evt_press` = 0 at the same latency.
2. **Glitch rejection.** Pulse `btn_in[0]` high for 3 cycles, then low. Expect no change to `btn_level`, no pulse, no event.
3. **Simultaneous edges with backpressure.** Raise channels 5, 1 and 6 on the same edge with `evt_ready` = 0 for 10 cycles, then 1.
   - Events are delivered as channel 1, then 5, then 6.
   - `evt_chan` holds at 1 while stalled.
   - `ovr` = 0.
4. **Overrun.** With `evt_ready` = 0, press then release channel 2 (two debounced edges), and separately raise channel 0.
   - `ovr` = 1.
   - The first event is channel 0, press.
   - The remaining channel-2 event is release (newest direction).
   - `ovr_clr` returns `ovr` to 0.
5. **Reset mid-debounce.** Hold `btn_in[4]` = 1 and assert `wb_rst_i` at cnt = 2.
   - All outputs return to their reset values.
   - After release, a press event follows at the full E6 latency measured from the first post-reset sample.
